pmem_responder: RTL and testbench

Synthesizable physical-memory responder that answers the CPU's cacheline burst requests on the `pmem_*` interface, the slave end of the same port the `mp4` top drives. It holds a line-organized backing store, applies a programmable fixed access latency, and returns or accepts four 64-bit beats per 256-bit line. It lets the full core run in synthesis or emulation without the behavioural testbench memory. The shadow-memory and RVFI checks stay valid because the beat ordering and handshake are identical.

---
 rtl/pmem_responder.sv | 139 +++++++++++++
 tb/tb_pmem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// pmem_responder: line-organized backing store answering pmem_* cacheline bursts.
// Latency: first beat LATENCY cycles after acceptance; 4 beats, then 1 recovery cycle.
// Backpressure: none; the initiator holds its request for the burst, and dropping it aborts.
// Ports: clk/rst (sync, active-low), pmem_read/pmem_write/pmem_address/pmem_wdata in;
//        pmem_rdata/pmem_resp beat outputs, busy (not idle), proto_err (sticky).
module pmem_responder #(
   parameter int LATENCY     = 10,
   parameter int BURST_LEN   = 4,
   parameter int DEPTH_LINES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pmem_read,
   input  logic        pmem_write,
   input  logic [31:0] pmem_address,
   input  logic [63:0] pmem_wdata,
   output logic [63:0] pmem_rdata,
   output logic        pmem_resp,
   output logic        busy,
   output logic        proto_err
);

   localparam int IDX_W  = $clog2(DEPTH_LINES);
   localparam int BEAT_W = $clog2(BURST_LEN);
   localparam int WORDS  = DEPTH_LINES * BURST_LEN;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

   state_t              state, state_n;
   logic [7:0]          lat_cnt, lat_cnt_n;
   logic [BEAT_W-1:0]   beat, beat_n;
   logic [IDX_W-1:0]    line, line_n;
   logic                dir_wr, dir_wr_n;
   logic                err_n;
   logic                req_live, req_other;
   logic                wr_en;
   logic [63:0]         rdata_n;

   // Backing store, one 64-bit word per beat; word address is {line, beat}.
   logic [63:0]         mem [WORDS];

   // Offset bits and aliased upper address bits are deliberately ignored.
   logic                unused_addr;
   assign unused_addr = ^{pmem_address[4:0], pmem_address[31:5+IDX_W]};

   // Request line of the latched direction, and the opposite one.
   assign req_live  = dir_wr ? pmem_write : pmem_read;
   assign req_other = dir_wr ? pmem_read  : pmem_write;

   always_comb begin
      state_n   = state;
      lat_cnt_n = lat_cnt;
      beat_n    = beat;
      line_n    = line;
      dir_wr_n  = dir_wr;
      err_n     = proto_err;
      unique case (state)
         S_IDLE: begin
            if (pmem_read && pmem_write) begin
               err_n = 1'b1;
            end else if (pmem_read || pmem_write) begin
               dir_wr_n  = pmem_write;
               line_n    = pmem_address[5 +: IDX_W];
               lat_cnt_n = 8'(LATENCY - 1);
               beat_n    = '0;
               // With a single-cycle latency the countdown is empty.
               state_n   = (LATENCY == 1) ? S_XFER : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!req_live) begin
               state_n = S_IDLE;
               err_n   = 1'b1;
            end else begin
               if (req_other) err_n = 1'b1;
               lat_cnt_n = lat_cnt - 8'd1;
               // Leaving on the edge where the count reaches 0 puts beat 0
               // exactly LATENCY cycles after acceptance.
               if (lat_cnt <= 8'd1) state_n = S_XFER;
            end
         end
         S_XFER: begin
            if (!req_live) begin
               state_n = S_IDLE;
               err_n   = 1'b1;
            end else begin
               if (req_other) err_n = 1'b1;
               if (beat == BEAT_W'(BURST_LEN - 1)) state_n = S_DONE;
               else                                beat_n  = beat + BEAT_W'(1);
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values, so read data is fetched
   // one cycle ahead at the upcoming {line, beat}.
   always_comb begin
      rdata_n = '0;
      if (state_n == S_XFER && !dir_wr_n) rdata_n = mem[{line_n, beat_n}];
   end

   // Beats are committed only while the write request is still held.
   assign wr_en = rst && (state == S_XFER) && dir_wr && pmem_write;

   always_ff @(posedge clk) begin
      if (wr_en) mem[{line, beat}] <= pmem_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         lat_cnt    <= '0;
         beat       <= '0;
         line       <= '0;
         dir_wr     <= 1'b0;
         proto_err  <= 1'b0;
         pmem_resp  <= 1'b0;
         pmem_rdata <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         lat_cnt    <= lat_cnt_n;
         beat       <= beat_n;
         line       <= line_n;
         dir_wr     <= dir_wr_n;
         proto_err  <= err_n;
         pmem_resp  <= (state_n == S_XFER);
         pmem_rdata <= rdata_n;
         busy       <= (state_n != S_IDLE);
      end
   end

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: two instances (LATENCY 10 and 1) share clock and reset.
module tb_pmem_responder;

   localparam int LAT0 = 10;
   localparam int LAT1 = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd   [2];
   logic        wr   [2];
   logic [31:0] addr [2];
   logic [63:0] wdat [2];
   logic [63:0] rdata[2];
   logic        resp [2];
   logic        busy [2];
   logic        perr [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   pmem_responder #(.LATENCY(LAT0), .BURST_LEN(4), .DEPTH_LINES(256)) dut0 (
      .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
      .pmem_address(addr[0]), .pmem_wdata(wdat[0]), .pmem_rdata(rdata[0]),
      .pmem_resp(resp[0]), .busy(busy[0]), .proto_err(perr[0]));

   pmem_responder #(.LATENCY(LAT1), .BURST_LEN(4), .DEPTH_LINES(256)) dut1 (
      .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
      .pmem_address(addr[1]), .pmem_wdata(wdat[1]), .pmem_rdata(rdata[1]),
      .pmem_resp(resp[1]), .busy(busy[1]), .proto_err(perr[1]));

   typedef struct {
      bit                w;
      logic [31:0]       a;
      logic [3:0][63:0]  d;
      logic [3:0][63:0]  exp;
   } vec_t;

   vec_t             tbl [6];
   logic [3:0][63:0] model [256];
   logic [7:0]       pool [6];

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One burst on instance s. drop_after >= 1 drops the request once that
   // many beats have been handed over (abort). Read beats come back in got.
   task automatic burst(input int s, input bit w, input logic [31:0] a,
                        input logic [3:0][63:0] wd, input int drop_after,
                        input string tag, output logic [3:0][63:0] got);
      int lat, nj, k, last, busy_last, zbad;
      bit prev;
      logic [31:0] rmask, bmask, exp_r, exp_b;
      lat       = (s == 0) ? LAT0 : LAT1;
      last      = (drop_after < 0) ? lat + 3 : lat + drop_after;
      busy_last = (drop_after < 0) ? lat + 4 : lat + drop_after;
      nj        = busy_last + 1;
      got = '0; rmask = '0; bmask = '0; exp_r = '0; exp_b = '0; zbad = 0; k = 0;
      addr[s] = a;
      wdat[s] = wd[0];
      if (w) wr[s] = 1'b1; else rd[s] = 1'b1;
      for (int j = 1; j <= nj; j++) begin
         prev = resp[s];
         tick();
         if (prev) k++;
         if (k < 4) wdat[s] = wd[k];
         if (resp[s]) begin
            rmask[j] = 1'b1;
            if (!w && k < 4) got[k] = rdata[s];
         end else if (rdata[s] != 64'd0) begin
            zbad++;
         end
         if (busy[s]) bmask[j] = 1'b1;
         if (drop_after >= 0 && k == drop_after) begin
            wr[s] = 1'b0;
            rd[s] = 1'b0;
         end
      end
      rd[s] = 1'b0;
      wr[s] = 1'b0;
      for (int j = 1; j <= nj; j++) begin
         exp_r[j] = (j >= lat && j <= last);
         exp_b[j] = (j <= busy_last);
      end
      check({tag, ".resp_window"}, 256'(rmask), 256'(exp_r));
      check({tag, ".busy_window"}, 256'(bmask), 256'(exp_b));
      check({tag, ".rdata_zero"},  256'(zbad),  256'(0));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0][63:0] got, old_d, new_d, exp;
      logic [31:0] a;
      int bad, c0, ln;
      bit w;

      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdat[s] = '0;
      end

      tbl[0] = '{1'b1, 32'h0000_0040,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, '0};
      tbl[1] = '{1'b0, 32'h0000_0040, '0,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
      tbl[2] = '{1'b1, 32'h0000_205F,
                 {64'hA4A4_0000_0000_00A4, 64'hA3A3_0000_0000_00A3,
                  64'hA2A2_0000_0000_00A2, 64'hA1A1_0000_0000_00A1}, '0};
      tbl[3] = '{1'b0, 32'h0000_0040, '0,
                 {64'hA4A4_0000_0000_00A4, 64'hA3A3_0000_0000_00A3,
                  64'hA2A2_0000_0000_00A2, 64'hA1A1_0000_0000_00A1}};
      tbl[4] = '{1'b1, 32'h0000_1FE0,
                 {64'hFFFF_0000_0000_0004, 64'hFFFF_0000_0000_0003,
                  64'hFFFF_0000_0000_0002, 64'hFFFF_0000_0000_0001}, '0};
      tbl[5] = '{1'b0, 32'hFFFF_FFE7, '0,
                 {64'hFFFF_0000_0000_0004, 64'hFFFF_0000_0000_0003,
                  64'hFFFF_0000_0000_0002, 64'hFFFF_0000_0000_0001}};

      // Reset held 2 cycles, then 20 quiet cycles.
      tick();
      tick();
      bad = 0;
      for (int s = 0; s < 2; s++)
         if (resp[s] || busy[s] || perr[s] || rdata[s] != 0) bad++;
      check("reset_outputs", 256'(bad), 256'(0));
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         for (int s = 0; s < 2; s++)
            if (resp[s] || busy[s] || perr[s] || rdata[s] != 0) bad++;
      end
      check("idle_quiet", 256'(bad), 256'(0));

      // Read and write together in IDLE.
      rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h40;
      tick();
      check("both_err", 256'(perr[0]), 256'(1));
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (resp[0] || busy[0]) bad++;
      end
      check("both_no_resp", 256'(bad), 256'(0));
      rd[0] = 1'b0; wr[0] = 1'b0;
      do_reset();
      tick();
      check("err_cleared", 256'(perr[0]), 256'(0));

      // Table vectors: write/read, offset and alias handling.
      for (int i = 0; i < 6; i++) begin
         burst(0, tbl[i].w, tbl[i].a, tbl[i].d, -1, $sformatf("vec%0d", i), got);
         if (!tbl[i].w) check($sformatf("vec%0d.rdata", i), 256'(got), 256'(tbl[i].exp));
         tick();
      end
      check("vec_no_err", 256'(perr[0]), 256'(0));

      // Abort after two write beats to line 5.
      old_d = {64'h0D0D_0D0D_0000_0003, 64'h0C0C_0C0C_0000_0002,
               64'h0B0B_0B0B_0000_0001, 64'h0A0A_0A0A_0000_0000};
      new_d = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
               64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
      burst(0, 1'b1, 32'h0000_00A0, old_d, -1, "abort_pre", got);
      tick();
      burst(0, 1'b1, 32'h0000_00A0, new_d, 2, "abort", got);
      check("abort_err", 256'(perr[0]), 256'(1));
      do_reset();
      tick();
      burst(0, 1'b0, 32'h0000_00A0, '0, -1, "abort_rd", got);
      exp = old_d;
      exp[0] = new_d[0];
      exp[1] = new_d[1];
      check("abort_rd.rdata", 256'(got), 256'(exp));

      // Reset during the latency countdown.
      rd[0] = 1'b1; addr[0] = 32'h0000_0040;
      tick();
      tick();
      tick();
      rst = 1'b0; rd[0] = 1'b0;
      tick();
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (resp[0] || busy[0]) bad++;
      end
      check("rst_in_wait", 256'(bad), 256'(0));

      // Randomized bursts against a line-level model.
      for (int i = 0; i < 6; i++) begin
         pool[i] = 8'($urandom_range(0, 255));
         model[pool[i]] = {{$urandom, $urandom}, {$urandom, $urandom},
                           {$urandom, $urandom}, {$urandom, $urandom}};
         a = $urandom;
         a[12:5] = pool[i];
         burst(0, 1'b1, a, model[pool[i]], -1, $sformatf("rinit%0d", i), got);
      end
      for (int i = 0; i < 30; i++) begin
         ln = pool[$urandom_range(0, 5)];
         a = $urandom;
         a[12:5] = 8'(ln);
         w = 1'($urandom_range(0, 1));
         if (w) begin
            exp = {{$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}};
            burst(0, 1'b1, a, exp, -1, $sformatf("rnd%0d", i), got);
            model[ln] = exp;
         end else begin
            burst(0, 1'b0, a, '0, -1, $sformatf("rnd%0d", i), got);
            check($sformatf("rnd%0d.rdata", i), 256'(got), 256'(model[ln]));
         end
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
      check("rnd_no_err", 256'(perr[0]), 256'(0));

      // Back-to-back reads at minimum spacing, LATENCY=1.
      exp = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
             64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
      burst(1, 1'b1, 32'h0000_00E0, exp, -1, "b2b_wr", got);
      c0 = cyc;
      for (int i = 0; i < 8; i++) begin
         burst(1, 1'b0, 32'h0000_00E0, '0, -1, $sformatf("b2b%0d", i), got);
         check($sformatf("b2b%0d.rdata", i), 256'(got), 256'(exp));
      end
      check("b2b_cycles", 256'(cyc - c0), 256'(48));
      check("b2b_idle", 256'(busy[1]), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
